// File: rtl/fft_in_pair_buf_if.sv
// Bundle between the frame pair buffer and its neighbours.
// The upstream sample stream and the FFT side share this bundle.
// master: the buffer itself.
// slave:  the environment, which is the sample source and the FFT.
interface fft_in_pair_buf_if #(
  parameter int unsigned DataW = 16
);

  typedef struct packed {
    logic signed [DataW-1:0] r;
    logic signed [DataW-1:0] i;
  } complex_product_t;

  logic             in_valid;
  complex_product_t in_data;
  logic             in_ready;
  logic             fft_done;
  complex_product_t data_0;
  complex_product_t data_1;
  logic             fft_enable;
  logic             frame_start;
  logic             busy;
  logic             timeout_err;

  modport master (
    input  in_valid, in_data, fft_done,
    output in_ready, data_0, data_1, fft_enable, frame_start, busy, timeout_err
  );

  modport slave (
    output in_valid, in_data, fft_done,
    input  in_ready, data_0, data_1, fft_enable, frame_start, busy, timeout_err
  );

endinterface

// File: rtl/fft_in_pair_buf.sv
// Frame pair buffer in front of a radix-2 FFT.
// It collects N serial samples, then bursts (x[k], x[k+N/2]) pairs for k = 0..N/2-1.
// After the burst it holds fft_enable until the FFT reports done, or until it times out.
module fft_in_pair_buf #(
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned DataW   = 16
) (
  input logic              clk,
  input logic              reset,
  fft_in_pair_buf_if.master bus
);

  localparam int unsigned Half    = N / 2;
  localparam int unsigned WrW     = $clog2(N);
  localparam int unsigned RdW     = $clog2(Half);
  localparam int unsigned CntW    = $clog2(TIMEOUT + 1);
  localparam int unsigned SampleW = 2 * DataW;

  typedef enum logic [1:0] {StFill, StBurst, StWait} state_e;

  state_e               state_q, state_d;
  logic [WrW-1:0]       wr_idx_q, wr_idx_d;
  logic [RdW-1:0]       rd_idx_q, rd_idx_d;
  logic [CntW-1:0]      wait_cnt_q, wait_cnt_d;
  logic [SampleW-1:0]   data_0_q, data_0_d;
  logic [SampleW-1:0]   data_1_q, data_1_d;
  logic                 fft_enable_q, fft_enable_d;
  logic                 frame_start_q, frame_start_d;
  logic                 busy_q, busy_d;
  logic                 timeout_err_q, timeout_err_d;

  logic [SampleW-1:0]   sample_q [N];

  logic accept;
  logic last_wr;
  logic last_rd;
  logic cnt_hit;

  assign accept  = (state_q == StFill) && bus.in_valid;
  assign last_wr = (wr_idx_q == WrW'(N - 1));
  assign last_rd = (rd_idx_q == RdW'(Half - 1));
  assign cnt_hit = (wait_cnt_q == CntW'(TIMEOUT - 1));

  // Sample storage; contents are don't-care after reset, so it has no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      sample_q[wr_idx_q] <= bus.in_data;
    end
  end

  // Next-state and registered-output decode.
  // Outputs are computed from the current state, which gives the one-cycle burst latency.
  // fft_enable and busy drop on the exit edge, so the cycle after done or timeout is idle.
  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    data_0_d      = '0;
    data_1_d      = '0;
    fft_enable_d  = 1'b0;
    frame_start_d = 1'b0;
    busy_d        = 1'b0;

    unique case (state_q)
      StFill: begin
        if (accept) begin
          wr_idx_d = wr_idx_q + 1'b1;
          if (last_wr) begin
            wr_idx_d = '0;
            rd_idx_d = '0;
            state_d  = StBurst;
          end
        end
      end

      StBurst: begin
        data_0_d      = sample_q[WrW'(rd_idx_q)];
        data_1_d      = sample_q[WrW'(rd_idx_q) + WrW'(Half)];
        fft_enable_d  = 1'b1;
        busy_d        = 1'b1;
        frame_start_d = (rd_idx_q == '0);
        rd_idx_d      = rd_idx_q + 1'b1;
        if (last_rd) begin
          rd_idx_d   = '0;
          wait_cnt_d = '0;
          state_d    = StWait;
        end
      end

      StWait: begin
        fft_enable_d = 1'b1;
        busy_d       = 1'b1;
        wait_cnt_d   = wait_cnt_q + 1'b1;
        // done wins over a coincident timeout
        if (bus.fft_done) begin
          fft_enable_d = 1'b0;
          busy_d       = 1'b0;
          wait_cnt_d   = '0;
          state_d      = StFill;
        end else if (cnt_hit) begin
          fft_enable_d  = 1'b0;
          busy_d        = 1'b0;
          wait_cnt_d    = '0;
          timeout_err_d = 1'b1;
          state_d       = StFill;
        end
      end

      default: begin
        state_d = StFill;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StFill;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      wait_cnt_q    <= '0;
      data_0_q      <= '0;
      data_1_q      <= '0;
      fft_enable_q  <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      wait_cnt_q    <= wait_cnt_d;
      data_0_q      <= data_0_d;
      data_1_q      <= data_1_d;
      fft_enable_q  <= fft_enable_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.in_ready    = (state_q == StFill);
  assign bus.data_0      = data_0_q;
  assign bus.data_1      = data_1_q;
  assign bus.fft_enable  = fft_enable_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
